mem_access_unit: RTL and testbench

- Sequential load/store unit between the multi-cycle CPU datapath and a variable-latency word-wide data memory.
- Accepts one request per transaction over a ready/req handshake.
- Generates the word-aligned address, byte enables and lane-replicated store data, then holds the memory request until acknowledged.
- Returns sign- or zero-extended load data with a one-cycle done pulse; detects misalignment and bus timeout.

---
 rtl/mem_access_unit_pkg.sv | 72 +++++++
 rtl/mem_access_unit_load_lane_ext.sv | 41 ++++
 rtl/mem_access_unit.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit.
// Contents: op-code and exception-code constants, FSM state encoding,
// lane-width constants, and small helpers that classify an op and build
// the store-side byte enables and replicated write data.
package mem_access_unit_pkg;

    // CPU op codes
    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LB  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LH  = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    // Exception codes reported alongside cpu_done
    localparam logic [1:0] EXC_NONE        = 2'b00;
    localparam logic [1:0] EXC_MISALIGN_LD = 2'b01;
    localparam logic [1:0] EXC_MISALIGN_ST = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT     = 2'b11;

    // Lane geometry of the 32-bit data bus
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return (op == OP_LHU) || (op == OP_LH) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // Halfwords need an even address, words need a multiple of four.
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        return (is_word(op) && (a != 2'b00)) || (is_half(op) && a[0]);
    endfunction

    // Byte enables; loads and SW always use the whole word.
    function automatic logic [LANES-1:0] store_be(input logic [2:0] op, input logic [1:0] a);
        case (op)
            OP_SB:   return 4'b0001 << a;
            OP_SH:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the right-justified store data onto every lane so the
    // byte enables alone select where it lands.
    function automatic logic [WORD_W-1:0] store_data(input logic [2:0] op,
                                                     input logic [WORD_W-1:0] wdata);
        case (op)
            OP_SB:   return {LANES{wdata[BYTE_W-1:0]}};
            OP_SH:   return {2{wdata[HALF_W-1:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_lane_ext.sv
// load_lane_ext: combinational lane select plus sign/zero extension of a
// memory read word.
// Ports:
//   op     in  3   load op code (store codes fall through as pass-through)
//   lane   in  2   byte address bits [1:0]
//   rdata  in  32  word returned by memory
//   result out 32  extended load value
module load_lane_ext
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [1:0]        lane,
    input  logic [WORD_W-1:0] rdata,
    output logic [WORD_W-1:0] result
);

    logic [BYTE_W-1:0] byte_lane [LANES];
    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign byte_lane[gi] = rdata[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_comb begin
        byte_sel = byte_lane[lane];
        // Halfword selection uses only A[1]; A[0] is ignored when unaligned
        // halfwords are allowed through.
        half_sel = lane[1] ? rdata[WORD_W-1:HALF_W] : rdata[HALF_W-1:0];
        case (op)
            OP_LBU:  result = {{(WORD_W-BYTE_W){1'b0}}, byte_sel};
            OP_LB:   result = {{(WORD_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
            OP_LHU:  result = {{(WORD_W-HALF_W){1'b0}}, half_sel};
            OP_LH:   result = {{(WORD_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequential load/store unit between the CPU datapath and
// a variable-latency word-wide data memory.
// Ports:
//   clk, reset                      clock and asynchronous active-high reset
//   cpu_req/op/addr/wdata           request side, sampled while cpu_ready=1
//   cpu_ready                       unit idle
//   cpu_done/exc/exc_code           one-cycle completion pulse and status
//   cpu_rdata                       extended load result, held between loads
//   mem_req/we/be/addr/wdata        memory request, held until mem_ack
//   mem_ack/mem_rdata               memory completion and read word
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT     = 255,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [2:0]        cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_exc,
    output logic [1:0]        cpu_exc_code,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    // Counter wide enough to hold TIMEOUT itself.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TIMEOUT_V = TIMEOUT[CNT_W:0];

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        lane_q, lane_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W:0]    cnt_inc;
    logic              timeout_hit;
    logic              cpu_ready_q, cpu_ready_d;
    logic              cpu_done_q, cpu_done_d;
    logic              cpu_exc_q, cpu_exc_d;
    logic [1:0]        exc_code_q, exc_code_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       load_result;

    load_lane_ext u_load_lane_ext (
        .op     (op_q),
        .lane   (lane_q),
        .rdata  (mem_rdata),
        .result (load_result)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        cpu_ready_d = cpu_ready_q;
        cpu_done_d  = 1'b0;
        cpu_exc_d   = cpu_exc_q;
        exc_code_d  = exc_code_q;
        cpu_rdata_d = cpu_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        cnt_inc     = {1'b0, cnt_q} + 1'b1;
        timeout_hit = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_V);

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    op_d        = cpu_op;
                    lane_d      = cpu_addr[1:0];
                    cpu_ready_d = 1'b0;
                    if (ALIGN_CHECK && misaligned(cpu_op, cpu_addr[1:0])) begin
                        // Fault straight away; the memory never sees it.
                        state_d    = ST_DONE;
                        cpu_done_d = 1'b1;
                        cpu_exc_d  = 1'b1;
                        exc_code_d = is_store(cpu_op) ? EXC_MISALIGN_ST : EXC_MISALIGN_LD;
                    end else begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store(cpu_op);
                        mem_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = store_be(cpu_op, cpu_addr[1:0]);
                        mem_wdata_d = store_data(cpu_op, cpu_wdata);
                    end
                end
            end

            ST_REQ: begin
                // An ack in the cycle the counter would expire still wins.
                if (mem_ack) begin
                    state_d    = ST_DONE;
                    mem_req_d  = 1'b0;
                    cpu_done_d = 1'b1;
                    cpu_exc_d  = 1'b0;
                    exc_code_d = EXC_NONE;
                    if (!is_store(op_q)) begin
                        cpu_rdata_d = load_result;
                    end
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                    if (timeout_hit) begin
                        state_d    = ST_DONE;
                        mem_req_d  = 1'b0;
                        cpu_done_d = 1'b1;
                        cpu_exc_d  = 1'b1;
                        exc_code_d = EXC_TIMEOUT;
                        if (!is_store(op_q)) begin
                            cpu_rdata_d = '0;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                cpu_ready_d = 1'b1;
                cpu_exc_d   = 1'b0;
                exc_code_d  = EXC_NONE;
            end

            default: begin
                state_d     = ST_IDLE;
                cpu_ready_d = 1'b1;
                mem_req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LW;
            lane_q      <= '0;
            cnt_q       <= '0;
            cpu_ready_q <= 1'b1;
            cpu_done_q  <= 1'b0;
            cpu_exc_q   <= 1'b0;
            exc_code_q  <= EXC_NONE;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_done_q  <= cpu_done_d;
            cpu_exc_q   <= cpu_exc_d;
            exc_code_q  <= exc_code_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu_ready    = cpu_ready_q;
    assign cpu_done     = cpu_done_q;
    assign cpu_exc      = cpu_exc_q;
    assign cpu_exc_code = exc_code_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_be       = mem_be_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (TIMEOUT=4, ALIGN_CHECK=1).
// A driver issues requests and pushes expected memory requests and expected
// completions; a memory responder and a completion monitor pop and compare.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int ADDR_W = 32;
    localparam int TMO    = 4;

    logic              clk;
    logic              reset;
    logic              cpu_req;
    logic [2:0]        cpu_op;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_ready;
    logic              cpu_done;
    logic [31:0]       cpu_rdata;
    logic              cpu_exc;
    logic [1:0]        cpu_exc_code;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TMO), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .cpu_exc(cpu_exc), .cpu_exc_code(cpu_exc_code),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         issue;
        int         lat;
        logic       exc;
        logic [1:0] code;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          issue;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] rdata;
    } mreq_t;

    exp_t        exp_q[$];
    mreq_t       mem_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] model_rdata = 32'h0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, expv);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference load value: shift the addressed lane down, mask, extend.
    function automatic logic [31:0] ld_model(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        logic [31:0] v;
        int unsigned sh;
        v = rd;
        if (op == OP_LBU || op == OP_LB) begin
            sh = 8 * (addr % 4);
            v  = (rd >> sh) & 32'hFF;
            if (op == OP_LB && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (op == OP_LHU || op == OP_LH) begin
            sh = 16 * ((addr / 2) % 2);
            v  = (rd >> sh) & 32'hFFFF;
            if (op == OP_LH && v >= 32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Wait for an idle unit (driving junk requests while busy), then issue.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int wait_n);
        int    guard;
        int    size;
        bit    store;
        bit    mis;
        exp_t  e;
        mreq_t m;
        guard = 0;
        @(negedge clk);
        while (!cpu_ready) begin
            cpu_req   = 1'($urandom);
            cpu_op    = 3'($urandom);
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            guard++;
            if (guard > 50) begin
                fail("ready_wait_expired");
                cpu_req = 1'b0;
                return;
            end
            @(negedge clk);
        end
        cpu_req   = 1'b1;
        cpu_op    = op;
        cpu_addr  = addr;
        cpu_wdata = wd;
        store = (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
        size  = (op == OP_LW || op == OP_SW) ? 4 :
                (op == OP_LBU || op == OP_LB || op == OP_SB) ? 1 : 2;
        mis   = (addr % size) != 0;
        e.issue = cyc;
        if (mis) begin
            e.lat  = 1;
            e.exc  = 1'b1;
            e.code = store ? 2'b10 : 2'b01;
        end else begin
            m.issue  = cyc;
            m.addr   = addr & ~32'h3;
            m.we     = store;
            m.be     = (!store || size == 4) ? 4'hF :
                       (size == 1) ? 4'(1 << (addr % 4)) :
                       ((addr % 4) >= 2) ? 4'hC : 4'h3;
            m.wdata  = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
            m.wait_n = wait_n;
            m.rdata  = rd;
            mem_q.push_back(m);
            if (wait_n >= TMO) begin
                e.lat  = TMO + 1;
                e.exc  = 1'b1;
                e.code = 2'b11;
                if (!store) model_rdata = 32'h0;
            end else begin
                e.lat  = wait_n + 2;
                e.exc  = 1'b0;
                e.code = 2'b00;
                if (!store) model_rdata = ld_model(op, addr, rd);
            end
        end
        e.rdata = model_rdata;
        exp_q.push_back(e);
        $display("TXN op=%0d addr=0x%08h wdata=0x%08h mrd=0x%08h wait=%0d -> exc=%0b code=%0d rdata=0x%08h lat=%0d",
                 op, addr, wd, rd, wait_n, e.exc, e.code, e.rdata, e.lat);
    endtask

    // Memory responder: checks each request cycle, acks after the planned wait.
    initial begin
        int    cnt;
        bit    active;
        mreq_t cur;
        cnt = 0;
        active = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        cur.issue = 0; cur.addr = 0; cur.we = 0; cur.be = 0;
        cur.wdata = 0; cur.wait_n = 0; cur.rdata = 0;
        forever begin
            @(negedge clk);
            if (reset || !mem_req) begin
                active    = 1'b0;
                cnt       = 0;
                mem_ack   = 1'($urandom);
                mem_rdata = $urandom;
            end else begin
                if (!active) begin
                    if (mem_q.size() == 0) begin
                        fail("unexpected_mem_req");
                        cur.issue = cyc - 1; cur.addr = mem_addr; cur.we = mem_we;
                        cur.be = mem_be; cur.wdata = mem_wdata; cur.wait_n = 0; cur.rdata = 0;
                    end else begin
                        cur = mem_q.pop_front();
                        check("mem_req_start_cycle", 32'(cyc), 32'(cur.issue + 1));
                    end
                    active = 1'b1;
                end
                check("mem_addr", mem_addr, cur.addr);
                check("mem_we", 32'(mem_we), 32'(cur.we));
                check("mem_be", 32'(mem_be), 32'(cur.be));
                if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                if (cnt >= TMO) fail("mem_req_held_past_timeout");
                mem_ack   = (cnt == cur.wait_n);
                mem_rdata = mem_ack ? cur.rdata : $urandom;
                cnt++;
            end
        end
    end

    // Completion monitor.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && cpu_done) begin
            if (exp_q.size() == 0) begin
                fail("unexpected_cpu_done");
            end else begin
                e = exp_q.pop_front();
                check("done_latency", 32'(cyc - e.issue), 32'(e.lat));
                check("cpu_exc", 32'(cpu_exc), 32'(e.exc));
                check("cpu_exc_code", 32'(cpu_exc_code), 32'(e.code));
                check("cpu_rdata", cpu_rdata, e.rdata);
                check("ready_low_at_done", 32'(cpu_ready), 32'h0);
            end
        end
    end

    initial begin
        int g;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_op = 3'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cpu_ready", 32'(cpu_ready), 32'h1);
        check("reset_mem_req", 32'(mem_req), 32'h0);
        check("reset_cpu_done", 32'(cpu_done), 32'h0);
        check("reset_cpu_rdata", cpu_rdata, 32'h0);
        check("reset_cpu_exc", 32'({cpu_exc, cpu_exc_code}), 32'h0);
        check("reset_mem_we_be", 32'({mem_we, mem_be}), 32'h0);
        reset = 1'b0;

        // Directed cases
        issue(OP_LB,  32'h0000_1003, 32'h0,         32'h80FF_7F01, 0);
        issue(OP_LW,  32'h0000_0006, 32'h0,         32'h0,         0);
        issue(OP_LHU, 32'h0000_2002, 32'h0,         32'hBEEF_1234, 3);
        issue(OP_LHU, 32'h0000_2002, 32'h0,         32'hBEEF_1234, 5);
        issue(OP_SB,  32'h0000_0001, 32'h0000_00A5, 32'h0,         0);
        issue(OP_SH,  32'h0000_0002, 32'h0000_1234, 32'h0,         1);
        issue(OP_SH,  32'h0000_0003, 32'h0000_1234, 32'h0,         0);
        issue(OP_SW,  32'h0000_0010, 32'hCAFE_F00D, 32'h0,         TMO);
        issue(OP_SW,  32'h0000_0010, 32'hCAFE_F00D, 32'h0,         TMO - 1);
        issue(OP_LH,  32'h0000_0042, 32'h0,         32'h8001_7FFF, 2);

        // Reset in the middle of a request
        issue(OP_LW, 32'h0000_0100, 32'h0, 32'h0, 99);
        g = 0;
        @(negedge clk);
        cpu_req = 1'b0;
        while (!mem_req && g < 10) begin
            @(negedge clk);
            g++;
        end
        if (!mem_req) fail("mem_req_never_rose");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_mem_req", 32'(mem_req), 32'h0);
        check("async_reset_cpu_ready", 32'(cpu_ready), 32'h1);
        exp_q.delete();
        mem_q.delete();
        model_rdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("ready_after_reset", 32'(cpu_ready), 32'h1);
        check("rdata_after_reset", cpu_rdata, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3) & 0);
            if ($urandom_range(0, 2) == 0) a = a | 32'($urandom_range(0, 3));
            issue(3'($urandom_range(0, 7)), a, $urandom, $urandom, $urandom_range(0, 6));
        end

        g = 0;
        @(negedge clk);
        cpu_req = 1'b0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) fail("drain_completions_expired");
        if (mem_q.size() != 0) fail("memory_requests_not_seen");
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
